// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcodes, FSM encoding and default sizes for the SPI RAM stage
package spi_ram_pkg;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    TX_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - byte-wide RAM, one synchronous write port and one registered read port
module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [MEM_DEPTH];

  // Array contents are deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI command decoder and RAM front end; SPI_RAM_AUTO_INC_EN enables address auto-increment
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err
);

  state_t               state;
  logic                 rx_valid_d;
  logic                 accept;
  logic [1:0]           opcode;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 rd_addr_vld;
  logic                 mem_wr_en;
  logic                 mem_rd_en;

  assign accept       = rx_valid & ~rx_valid_d;
  assign opcode       = rx_data[9:8];
  assign payload      = rx_data[7:0];
  assign payload_addr = payload[ADDR_SIZE-1:0];

  assign mem_wr_en = accept && (state == IDLE) && (opcode == OP_WR_DATA);
  assign mem_rd_en = accept && (state == IDLE) && (opcode == OP_RD_DATA);

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;
`endif

  spi_ram_mem #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mem_wr_en),
    .wr_addr(wr_addr),
    .wr_data(payload),
    .rd_en  (mem_rd_en),
    .rd_addr(rd_addr),
    .rd_data(tx_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_valid_d  <= 1'b0;
      tx_valid    <= 1'b0;
      cmd_err     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_addr_vld <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      cmd_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (opcode)
              OP_WR_ADDR: wr_addr <= payload_addr;
              OP_WR_DATA: begin
`ifdef SPI_RAM_AUTO_INC_EN
                wr_addr <= wr_addr + ADDR_ONE;
`endif
              end
              OP_RD_ADDR: begin
                rd_addr     <= payload_addr;
                rd_addr_vld <= 1'b1;
              end
              default: begin
                // A read without an address is still served so the SPI slave never stalls.
                tx_valid <= 1'b1;
                cmd_err  <= ~rd_addr_vld;
                state    <= TX_HOLD;
`ifdef SPI_RAM_AUTO_INC_EN
                rd_addr <= rd_addr + ADDR_ONE;
`else
                rd_addr_vld <= 1'b0;
`endif
              end
            endcase
          end
        end
        TX_HOLD: begin
          if (!rx_valid) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
